// File: rtl/ddr_in_pkg.sv
// Shared types and helpers for the DDR input capture block.
package ddr_in_pkg;

  // Alignment of the rise/fall samples presented on q_rise_o/q_fall_o.
  typedef enum logic [1:0] {
    DDR_OPPOSITE_EDGE       = 2'd0,
    DDR_SAME_EDGE           = 2'd1,
    DDR_SAME_EDGE_PIPELINED = 2'd2
  } ddr_mode_e;

  // Width of a packed output word: PACK beats of one rise + one fall sample.
  function automatic int unsigned ddr_word_w(input int unsigned width, input int unsigned pack);
    return 2 * width * pack;
  endfunction

endpackage

// File: rtl/ddr_in_edge_pair.sv
// WIDTH-wide DDR capture flop pair with selectable output alignment and
// a per-beat valid strobe. A beat is the rise sample at posedge k plus the
// fall sample at the following negedge.
module ddr_in_edge_pair
  import ddr_in_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter ddr_mode_e   MODE  = DDR_SAME_EDGE_PIPELINED
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic             set_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_rise_o,
  output logic [WIDTH-1:0] q_fall_o,
  output logic [WIDTH-1:0] al_rise_o,
  output logic [WIDTH-1:0] al_fall_o,
  output logic             pair_valid_o
);

  logic [WIDTH-1:0] cap_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] rise_al_q;
  logic [WIDTH-1:0] fall_al_q;
  logic             rise_ce_q;
  logic             beat_v_q;
  logic             pair_valid_q;

  // Capture value shared by both edge flops: reset beats set beats data.
  always_comb begin
    if (!rst_ni) begin
      cap_d = '0;
    end else if (set_i) begin
      cap_d = '1;
    end else begin
      cap_d = d_i;
    end
  end

  // Rise capture flop; holds (including through reset) while ce_i is low.
  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      rise_q <= cap_d;
    end
  end

  // Fall capture flop; holds (including through reset) while ce_i is low.
  always_ff @(negedge clk_i) begin
    if (ce_i) begin
      fall_q <= cap_d;
    end
  end

  // Beat validity half-way point: rise enable seen at the negedge.
  always_ff @(negedge clk_i) begin
    if (!rst_ni) begin
      beat_v_q <= 1'b0;
    end else begin
      beat_v_q <= rise_ce_q & ce_i;
    end
  end

  // Posedge bookkeeping: rise enable, pipelined pair and its valid strobe.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rise_ce_q    <= 1'b0;
      pair_valid_q <= 1'b0;
      rise_al_q    <= '0;
      fall_al_q    <= '0;
    end else begin
      rise_ce_q    <= ce_i;
      pair_valid_q <= beat_v_q;
      rise_al_q    <= rise_q;
      fall_al_q    <= fall_q;
    end
  end

  // Output alignment select; every source is a flop.
  always_comb begin
    case (MODE)
      DDR_OPPOSITE_EDGE: begin
        q_rise_o = rise_q;
        q_fall_o = fall_q;
      end
      DDR_SAME_EDGE: begin
        // Fall sample of the previous beat next to the current rise sample.
        q_rise_o = rise_q;
        q_fall_o = fall_al_q;
      end
      default: begin
        q_rise_o = rise_al_q;
        q_fall_o = fall_al_q;
      end
    endcase
  end

  assign al_rise_o    = rise_al_q;
  assign al_fall_o    = fall_al_q;
  assign pair_valid_o = pair_valid_q;

endmodule

// File: rtl/ddr_in_capture.sv
// DDR input capture for the SD host data path: edge capture, beat
// alignment, and packing of PACK beats into one word behind valid/ready
// with a sticky overflow flag for dropped words.
module ddr_in_capture
  import ddr_in_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter ddr_mode_e   MODE   = DDR_SAME_EDGE_PIPELINED,
  parameter int unsigned PACK   = 2,
  localparam int unsigned WORD_W = ddr_word_w(WIDTH, PACK)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ce_i,
  input  logic              set_i,
  input  logic [WIDTH-1:0]  d_i,
  output logic [WIDTH-1:0]  q_rise_o,
  output logic [WIDTH-1:0]  q_fall_o,
  output logic              pair_valid_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  input  logic              flush_i,
  output logic              overflow_o
);

  localparam int unsigned BEAT_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;

  if (PACK < 1) begin : g_bad_pack
    $error("ddr_in_capture: PACK must be at least 1");
  end
  if ((MODE != DDR_OPPOSITE_EDGE) && (MODE != DDR_SAME_EDGE) &&
      (MODE != DDR_SAME_EDGE_PIPELINED)) begin : g_bad_mode
    $error("ddr_in_capture: unsupported MODE");
  end

  logic [WIDTH-1:0]  al_rise_s;
  logic [WIDTH-1:0]  al_fall_s;
  logic              pair_valid_s;
  logic [BEAT_W-1:0] beat_s;
  logic [WORD_W-1:0] filled_s;
  logic              accept_s;
  logic              last_s;

  logic [CNT_W-1:0]  beat_cnt_q,   beat_cnt_d;
  logic [WORD_W-1:0] partial_q,    partial_d;
  logic [WORD_W-1:0] word_q,       word_d;
  logic              word_valid_q, word_valid_d;
  logic              overflow_q,   overflow_d;

  ddr_in_edge_pair #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_edge_pair (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .ce_i         (ce_i),
    .set_i        (set_i),
    .d_i          (d_i),
    .q_rise_o     (q_rise_o),
    .q_fall_o     (q_fall_o),
    .al_rise_o    (al_rise_s),
    .al_fall_o    (al_fall_s),
    .pair_valid_o (pair_valid_s)
  );

  // Packer next state: merge the aligned pair MSB-first, hand off or drop.
  always_comb begin
    beat_s   = {al_rise_s, al_fall_s};
    filled_s = partial_q;
    for (int i = 0; i < int'(PACK); i++) begin
      filled_s[WORD_W-1-i*BEAT_W -: BEAT_W] =
        (beat_cnt_q == CNT_W'(i)) ? beat_s : filled_s[WORD_W-1-i*BEAT_W -: BEAT_W];
    end
    accept_s = word_valid_q & word_ready_i;
    last_s   = (beat_cnt_q == CNT_W'(PACK - 1));

    beat_cnt_d   = beat_cnt_q;
    partial_d    = partial_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overflow_d   = overflow_q;

    if (flush_i) begin
      // Flush wins over any same-cycle completion or handshake.
      beat_cnt_d   = '0;
      partial_d    = '0;
      word_valid_d = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      if (accept_s) begin
        word_valid_d = 1'b0;
      end else begin
        word_valid_d = word_valid_q;
      end
      if (pair_valid_s) begin
        if (last_s) begin
          beat_cnt_d = '0;
          partial_d  = '0;
          if (!word_valid_q || accept_s) begin
            word_d       = filled_s;
            word_valid_d = 1'b1;
          end else begin
            // Held word is still pending: keep it, drop the new one.
            overflow_d = 1'b1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          partial_d  = filled_s;
        end
      end else begin
        beat_cnt_d = beat_cnt_q;
      end
    end
  end

  // Packer state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      beat_cnt_q   <= '0;
      partial_q    <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      partial_q    <= partial_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign pair_valid_o = pair_valid_s;
  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_ddr_in_capture.sv
// Directed bench for ddr_in_capture: pipelined, same-edge and opposite-edge
// instances share one stimulus stream.
module tb_ddr_in_capture;
  import ddr_in_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, ce, set, flush, ready;
  logic [3:0]  d;

  logic [3:0]  p_qr, p_qf, s_qr, s_qf, o_qr, o_qf;
  logic        p_pv, s_pv, o_pv, p_wv, s_wv, o_wv, p_ov, s_ov, o_ov;
  logic [15:0] p_word, s_word, o_word;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr_in_capture #(.WIDTH(4), .MODE(DDR_SAME_EDGE_PIPELINED), .PACK(2)) u_pipe (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .set_i(set), .d_i(d),
    .q_rise_o(p_qr), .q_fall_o(p_qf), .pair_valid_o(p_pv), .word_o(p_word),
    .word_valid_o(p_wv), .word_ready_i(ready), .flush_i(flush), .overflow_o(p_ov));

  ddr_in_capture #(.WIDTH(4), .MODE(DDR_SAME_EDGE), .PACK(2)) u_same (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .set_i(set), .d_i(d),
    .q_rise_o(s_qr), .q_fall_o(s_qf), .pair_valid_o(s_pv), .word_o(s_word),
    .word_valid_o(s_wv), .word_ready_i(ready), .flush_i(flush), .overflow_o(s_ov));

  ddr_in_capture #(.WIDTH(4), .MODE(DDR_OPPOSITE_EDGE), .PACK(2)) u_opp (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .set_i(set), .d_i(d),
    .q_rise_o(o_qr), .q_fall_o(o_qf), .pair_valid_o(o_pv), .word_o(o_word),
    .word_valid_o(o_wv), .word_ready_i(ready), .flush_i(flush), .overflow_o(o_ov));

  // One beat: rise data before the posedge, fall data before the negedge.
  // Returns 2 time units after the posedge that samples the rise value.
  task automatic beat(input logic [3:0] r, input logic [3:0] f,
                      input logic cer, input logic cef, input logic st);
    @(negedge clk); #2; d = r; ce = cer; set = st;
    @(posedge clk); #2; d = f; ce = cef; set = st;
  endtask

  task automatic idle();
    beat(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; set = 1'b0; flush = 1'b0; ready = 1'b0; d = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (p_qr !== 4'h0) begin errors++; $display("FAIL reset_qrise got %h exp 0", p_qr); end
    checks++; if (p_qf !== 4'h0) begin errors++; $display("FAIL reset_qfall got %h exp 0", p_qf); end
    checks++; if (p_pv !== 1'b0) begin errors++; $display("FAIL reset_pv got %b exp 0", p_pv); end
    checks++; if (p_word !== 16'h0000) begin errors++; $display("FAIL reset_word got %h exp 0000", p_word); end
    checks++; if (p_wv !== 1'b0) begin errors++; $display("FAIL reset_wv got %b exp 0", p_wv); end
    checks++; if (p_ov !== 1'b0) begin errors++; $display("FAIL reset_ov got %b exp 0", p_ov); end
    checks++; if ({o_qr, o_qf} !== 8'h00) begin errors++; $display("FAIL reset_opp got %h exp 00", {o_qr, o_qf}); end
    rst_n = 1'b1; ce = 1'b0; d = 4'h0;
  endtask

  task automatic test_pipelined();
    ready = 1'b1;
    beat(4'hA, 4'h5, 1'b1, 1'b1, 1'b0);
    beat(4'h3, 4'hC, 1'b1, 1'b1, 1'b0);
    checks++; if (p_pv !== 1'b1) begin errors++; $display("FAIL pipe_pv0 got %b exp 1", p_pv); end
    checks++; if ({p_qr, p_qf} !== 8'hA5) begin errors++; $display("FAIL pipe_pair0 got %h exp A5", {p_qr, p_qf}); end
    idle();
    checks++; if ({p_qr, p_qf} !== 8'h3C) begin errors++; $display("FAIL pipe_pair1 got %h exp 3C", {p_qr, p_qf}); end
    checks++; if (p_pv !== 1'b1) begin errors++; $display("FAIL pipe_pv1 got %b exp 1", p_pv); end
    checks++; if (p_wv !== 1'b0) begin errors++; $display("FAIL pipe_wv_early got %b exp 0", p_wv); end
    idle();
    checks++; if (p_wv !== 1'b1) begin errors++; $display("FAIL pipe_wv got %b exp 1", p_wv); end
    checks++; if (p_word !== 16'hA53C) begin errors++; $display("FAIL pipe_word got %h exp A53C", p_word); end
    checks++; if (p_pv !== 1'b0) begin errors++; $display("FAIL pipe_pv_idle got %b exp 0", p_pv); end
    idle();
    checks++; if (p_wv !== 1'b0) begin errors++; $display("FAIL pipe_accept got %b exp 0", p_wv); end
    checks++; if (p_word !== 16'hA53C) begin errors++; $display("FAIL pipe_word_hold got %h exp A53C", p_word); end
  endtask

  task automatic test_same_edge();
    beat(4'h1, 4'h9, 1'b1, 1'b1, 1'b0);
    beat(4'h2, 4'h8, 1'b1, 1'b1, 1'b0);
    checks++; if ({s_qr, s_qf} !== 8'h29) begin errors++; $display("FAIL same_pair0 got %h exp 29", {s_qr, s_qf}); end
    checks++; if ({p_qr, p_qf} !== 8'h19) begin errors++; $display("FAIL same_pipe0 got %h exp 19", {p_qr, p_qf}); end
    beat(4'h3, 4'h7, 1'b1, 1'b1, 1'b0);
    checks++; if ({s_qr, s_qf} !== 8'h38) begin errors++; $display("FAIL same_pair1 got %h exp 38", {s_qr, s_qf}); end
    checks++; if ({p_qr, p_qf} !== 8'h28) begin errors++; $display("FAIL same_pipe1 got %h exp 28", {p_qr, p_qf}); end
    idle();
    idle();
  endtask

  task automatic test_opposite();
    ce = 1'b1; d = 4'h5;
    @(negedge clk); #1;
    checks++; if (o_qf !== 4'h5) begin errors++; $display("FAIL opp_fall_neg got %h exp 5", o_qf); end
    checks++; if (s_qf !== 4'h7) begin errors++; $display("FAIL same_fall_neg got %h exp 7", s_qf); end
    #1; d = 4'h6;
    @(posedge clk); #1;
    checks++; if ({o_qr, o_qf} !== 8'h65) begin errors++; $display("FAIL opp_pos got %h exp 65", {o_qr, o_qf}); end
    checks++; if ({s_qr, s_qf} !== 8'h65) begin errors++; $display("FAIL same_pos got %h exp 65", {s_qr, s_qf}); end
    checks++; if ({p_qr, p_qf} !== 8'h35) begin errors++; $display("FAIL pipe_pos got %h exp 35", {p_qr, p_qf}); end
    ce = 1'b0;
    #1;
    do_flush();
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    beat(4'hA, 4'h5, 1'b1, 1'b1, 1'b0);
    beat(4'h3, 4'hC, 1'b1, 1'b1, 1'b0);
    beat(4'h1, 4'h1, 1'b1, 1'b1, 1'b0);
    beat(4'h2, 4'h2, 1'b1, 1'b1, 1'b0);
    idle();
    idle();
    checks++; if (p_wv !== 1'b1) begin errors++; $display("FAIL ovf_wv got %b exp 1", p_wv); end
    checks++; if (p_word !== 16'hA53C) begin errors++; $display("FAIL ovf_word got %h exp A53C", p_word); end
    checks++; if (p_ov !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", p_ov); end
    ready = 1'b1;
    idle();
    checks++; if (p_wv !== 1'b0) begin errors++; $display("FAIL ovf_accept got %b exp 0", p_wv); end
    checks++; if (p_ov !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", p_ov); end
    do_flush();
    checks++; if (p_ov !== 1'b0) begin errors++; $display("FAIL ovf_flush got %b exp 0", p_ov); end
  endtask

  task automatic test_ce_set();
    ready = 1'b1;
    beat(4'hA, 4'h5, 1'b1, 1'b1, 1'b0);
    beat(4'h3, 4'hC, 1'b1, 1'b0, 1'b0);
    beat(4'h1, 4'h2, 1'b1, 1'b1, 1'b0);
    checks++; if (p_pv !== 1'b0) begin errors++; $display("FAIL ce_pv_gap got %b exp 0", p_pv); end
    idle();
    checks++; if (p_wv !== 1'b0) begin errors++; $display("FAIL ce_wv_early got %b exp 0", p_wv); end
    idle();
    checks++; if (p_wv !== 1'b1) begin errors++; $display("FAIL ce_wv got %b exp 1", p_wv); end
    checks++; if (p_word !== 16'hA512) begin errors++; $display("FAIL ce_word got %h exp A512", p_word); end
    beat(4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
    beat(4'h1, 4'h2, 1'b1, 1'b1, 1'b0);
    idle();
    idle();
    checks++; if (p_wv !== 1'b1) begin errors++; $display("FAIL set_wv got %b exp 1", p_wv); end
    checks++; if (p_word !== 16'hFF12) begin errors++; $display("FAIL set_word got %h exp FF12", p_word); end
  endtask

  task automatic test_flush_collision();
    ready = 1'b0;
    do_flush();
    beat(4'h1, 4'h1, 1'b1, 1'b1, 1'b0);
    beat(4'h2, 4'h2, 1'b1, 1'b1, 1'b0);
    beat(4'h3, 4'h3, 1'b1, 1'b1, 1'b0);
    beat(4'h4, 4'h4, 1'b1, 1'b1, 1'b0);
    idle();
    checks++; if (p_wv !== 1'b1) begin errors++; $display("FAIL fl_wv_pre got %b exp 1", p_wv); end
    checks++; if (p_word !== 16'h1122) begin errors++; $display("FAIL fl_word_pre got %h exp 1122", p_word); end
    flush = 1'b1;
    idle();
    flush = 1'b0;
    checks++; if (p_wv !== 1'b0) begin errors++; $display("FAIL fl_wv got %b exp 0", p_wv); end
    checks++; if (p_ov !== 1'b0) begin errors++; $display("FAIL fl_ov got %b exp 0", p_ov); end
    idle();
    checks++; if (p_wv !== 1'b0) begin errors++; $display("FAIL fl_no_word got %b exp 0", p_wv); end
    ready = 1'b1;
    beat(4'h5, 4'h5, 1'b1, 1'b1, 1'b0);
    beat(4'h6, 4'h6, 1'b1, 1'b1, 1'b0);
    idle();
    idle();
    checks++; if (p_wv !== 1'b1) begin errors++; $display("FAIL fl_cnt_wv got %b exp 1", p_wv); end
    checks++; if (p_word !== 16'h5566) begin errors++; $display("FAIL fl_cnt_word got %h exp 5566", p_word); end
  endtask

  task automatic test_reset_midword();
    beat(4'h1, 4'h1, 1'b1, 1'b1, 1'b0);
    idle();
    rst_n = 1'b0; ce = 1'b1; d = 4'hF;
    @(posedge clk); #2;
    checks++; if ({p_qr, p_qf, o_qr} !== 12'h000) begin errors++; $display("FAIL rst_q got %h exp 000", {p_qr, p_qf, o_qr}); end
    checks++; if (p_pv !== 1'b0) begin errors++; $display("FAIL rst_pv got %b exp 0", p_pv); end
    checks++; if (p_word !== 16'h0000) begin errors++; $display("FAIL rst_word got %h exp 0000", p_word); end
    checks++; if ({p_wv, p_ov} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {p_wv, p_ov}); end
    @(negedge clk); #1;
    checks++; if (o_qf !== 4'h0) begin errors++; $display("FAIL rst_fall got %h exp 0", o_qf); end
    #1; rst_n = 1'b1; ce = 1'b0; d = 4'h0;
    beat(4'h6, 4'h6, 1'b1, 1'b1, 1'b0);
    beat(4'h7, 4'h7, 1'b1, 1'b1, 1'b0);
    idle();
    idle();
    checks++; if (p_wv !== 1'b1) begin errors++; $display("FAIL rst_after_wv got %b exp 1", p_wv); end
    checks++; if (p_word !== 16'h6677) begin errors++; $display("FAIL rst_after_word got %h exp 6677", p_word); end
  endtask

  initial begin
    test_reset();
    test_pipelined();
    test_same_edge();
    test_opposite();
    test_overflow();
    test_ce_set();
    test_flush_collision();
    test_reset_midword();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ddr_in_capture.md
Name: ddr_in_capture

Overview:
- Parametrised DDR input capture for the SD host data path (DAT[3:0] in DDR50).
- Samples WIDTH lanes on both clock edges and aligns each rise/fall pair per a selectable edge mode.
- Packs aligned pairs into PACK-beat words behind a valid/ready handshake, with a sticky overflow flag.
- Generalises the single-bit, opposite-edge-only DDR input flop pair.

Parameters:
- WIDTH, 4, number of data lanes.
- MODE, DDR_SAME_EDGE_PIPELINED, one of DDR_OPPOSITE_EDGE / DDR_SAME_EDGE / DDR_SAME_EDGE_PIPELINED; selects q_rise_o/q_fall_o timing only.
- PACK, 2, beats per output word (>=1); WORD_W = 2*WIDTH*PACK.

Ports:
- clk_i  in  1  clock; both edges used for capture.
- rst_ni  in  1  synchronous active-low reset.
- ce_i  in  1  capture enable; sampled at each edge by that edge's flop.
- set_i  in  1  synchronous set; captures all-ones instead of d_i.
- d_i  in  WIDTH  DDR input lanes.
- q_rise_o  out  WIDTH  rising-edge sample, timed per MODE.
- q_fall_o  out  WIDTH  falling-edge sample, timed per MODE.
- pair_valid_o  out  1  aligned pair valid (pipelined alignment).
- word_o  out  WORD_W  packed word.
- word_valid_o  out  1  word available.
- word_ready_i  in  1  consumer accepts word.
- flush_i  in  1  discard partial and held word, clear overflow.
- overflow_o  out  1  sticky: completed word dropped.

Behaviour:
- Capture priority, every edge flop: reset > set > d_i. Flops hold when ce_i=0. Reset and set act only with ce_i=1, matching the predecessor; rst_ni additionally clears all non-capture state regardless of ce_i.
- The rise flop (posedge) and fall flop (negedge) both clear to 0 while rst_ni=0; the fall flop clears on the negedge.
- A beat k is defined by the rise sample at posedge k plus the fall sample at the following negedge. A beat is valid only if ce_i=1 at both edges.
- DDR_OPPOSITE_EDGE: q_rise_o changes at posedge, q_fall_o changes at negedge (raw flops).
- DDR_SAME_EDGE: both outputs change at posedge k+1. q_rise_o = rise sample at posedge k+1; q_fall_o = fall sample of beat k (the pair straddles two beats).
- DDR_SAME_EDGE_PIPELINED: at posedge k+1, q_rise_o = rise of beat k and q_fall_o = fall of beat k. Latency is 1 cycle.
- pair_valid_o: registered at posedge k+1; high for one cycle per valid beat, independent of MODE.
- Packer always consumes the pipelined-aligned pair.
  - Beat layout: {rise, fall}, rise in the MSBs.
  - Beats fill word MSB-first: the first beat occupies [WORD_W-1 -: 2*WIDTH].
  - beat_cnt counts 0..PACK-1 and wraps to 0 when a word completes.
- Word completion, at the edge where the PACK-th valid pair enters the packer:
  - Output register empty, or (word_valid_o & word_ready_i) in that cycle: load word_o, word_valid_o=1 next cycle. No overflow.
  - Otherwise: drop the new word, keep the held word, set overflow_o=1 (sticky).
- word_valid_o & word_ready_i without a completion: word_valid_o=0 next cycle. word_o holds its last value.
- word_o is stable while word_valid_o=1 and not accepted.
- flush_i (sampled at posedge): next cycle beat_cnt=0, partial word cleared, word_valid_o=0, overflow_o=0. Flush beats a same-cycle completion or handshake; the arriving pair is discarded.
- Reset values: q_rise_o=0, q_fall_o=0, pair_valid_o=0, word_o=0, word_valid_o=0, overflow_o=0, beat_cnt=0.
- Reset mid-word: the partial word is discarded and the first beat after rst_ni rises is beat 0.
- Invalid MODE or PACK<1: elaboration $error.

Decomposition:
- Package ddr_in_pkg: enum ddr_mode_e {DDR_OPPOSITE_EDGE, DDR_SAME_EDGE, DDR_SAME_EDGE_PIPELINED}, plus WORD_W helper function.
- Sub-module ddr_in_edge_pair: WIDTH-wide posedge/negedge flops, MODE alignment, pair_valid generation.
- Packer and handshake live in ddr_in_capture.

Test Plan:
- WIDTH=4, PACK=2, PIPELINED. Beats (rise,fall) = (A,5),(3,C), ready=1 -> word_o=16'hA53C and word_valid_o one cycle after the second pair_valid_o; q_rise_o/q_fall_o = A/5, then 3/C.
- DDR_SAME_EDGE, rise stream 1,2,3 and fall stream 9,8,7 -> at posedge k+1 the outputs are (2,9), then (3,8).
- ready=0. Send 4 beats A5,3C,11,22 -> word_o holds A53C, overflow_o=1. Then ready=1 -> accepted; overflow_o stays 1 until flush_i.
- ce_i=0 during the fall edge of beat 2 -> that beat is not counted; word completes one beat later. set_i=1 with ce_i=1 -> pair F/F counted as data.
- flush_i on the same cycle as the 2nd beat with word_valid_o=1 -> next cycle word_valid_o=0, beat_cnt=0, overflow_o=0, no word emitted.
- rst_ni=0 for 1 cycle after beat 1 -> all outputs 0. Subsequent beats (6,6),(7,7) -> word 16'h6677.
